// File: rtl/playback_sequencer.sv
// Sample-rate scheduler and flash read master for the audio playback path.
// One sample per programmable tick: pulse the address generator, fetch a flash word if it is fresh, and emit a 16-bit half.
module playback_sequencer #(
    parameter logic [15:0] DIV_DEFAULT = 16'd1136,
    parameter logic [15:0] DIV_STEP    = 16'd32,
    parameter logic [15:0] DIV_MIN     = 16'd256,
    parameter logic [15:0] DIV_MAX     = 16'd4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  keyboard_in,
    input  logic        key_data_ready,
    input  logic        spd_up,
    input  logic        spd_dn,
    input  logic        spd_rst,
    output logic        gen_start,
    output logic        back_mode,
    input  logic [22:0] gen_addr,
    input  logic        gen_is_old,
    input  logic        gen_finish,
    output logic        flash_read,
    output logic [22:0] flash_address,
    input  logic        flash_waitrequest,
    input  logic [31:0] flash_readdata,
    input  logic        flash_readdatavalid,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        playing,
    output logic [15:0] divider
);

    localparam logic [7:0] KEY_PLAY  = 8'h24;
    localparam logic [7:0] KEY_PAUSE = 8'h23;
    localparam logic [7:0] KEY_BACK  = 8'h32;
    localparam logic [7:0] KEY_FWD   = 8'h2b;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GEN,
        READ,
        WAIT_DATA,
        EMIT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tick_cnt;
    logic [15:0] active_div;
    logic        tick_wrap;
    logic        tick_pending;
    logic [31:0] word_reg;
    logic        dir_latched;
    logic        sel_high;
    logic        half_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            playing   <= 1'b0;
            back_mode <= 1'b0;
        end else if (key_data_ready) begin
            case (keyboard_in)
                KEY_PLAY:  playing   <= 1'b1;
                KEY_PAUSE: playing   <= 1'b0;
                KEY_BACK:  back_mode <= 1'b1;
                KEY_FWD:   back_mode <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= DIV_DEFAULT;
        end else if (spd_rst) begin
            divider <= DIV_DEFAULT;
        end else if (spd_up) begin
            divider <= (divider < DIV_MIN + DIV_STEP) ? DIV_MIN : divider - DIV_STEP;
        end else if (spd_dn) begin
            divider <= (divider > DIV_MAX - DIV_STEP) ? DIV_MAX : divider + DIV_STEP;
        end
    end

    // The counter compares against a copy of the divider taken at each wrap,
    // so a speed change never truncates or stretches the period in progress.
    assign tick_wrap = playing && (tick_cnt == active_div - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= 16'd0;
            active_div <= DIV_DEFAULT;
        end else if (!playing || tick_wrap) begin
            tick_cnt   <= 16'd0;
            active_div <= divider;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_pending <= 1'b0;
        end else if (tick_wrap) begin
            tick_pending <= 1'b1;
        end else if (!playing || state == IDLE) begin
            tick_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        gen_start    = 1'b0;
        sample_valid = 1'b0;
        case (state)
            IDLE:      if (tick_pending) state_nxt = ARM;
            ARM: begin
                gen_start = 1'b1;
                state_nxt = GEN;
            end
            GEN:       if (gen_finish) state_nxt = gen_is_old ? READ : EMIT;
            READ:      if (!flash_waitrequest) state_nxt = WAIT_DATA;
            WAIT_DATA: if (flash_readdatavalid) state_nxt = EMIT;
            EMIT: begin
                sample_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // Fresh words play their "first" half for the current direction, reused
    // words the other half; this selection is frozen when GEN finishes.
    assign half_sel = dir_latched ~^ gen_is_old;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_latched   <= 1'b0;
            sel_high      <= 1'b0;
            flash_read    <= 1'b0;
            flash_address <= 23'd0;
            word_reg      <= 32'd0;
            sample        <= 16'd0;
        end else begin
            case (state)
                ARM: dir_latched <= back_mode;
                GEN: begin
                    if (gen_finish) begin
                        sel_high <= half_sel;
                        if (gen_is_old) begin
                            flash_read    <= 1'b1;
                            flash_address <= gen_addr;
                        end else begin
                            sample <= half_sel ? word_reg[31:16] : word_reg[15:0];
                        end
                    end
                end
                READ: if (!flash_waitrequest) flash_read <= 1'b0;
                WAIT_DATA: begin
                    if (flash_readdatavalid) begin
                        word_reg <= flash_readdata;
                        sample   <= sel_high ? flash_readdata[31:16] : flash_readdata[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
